video_byte_packer: RTL

VIDEO_BYTE_PACKER -- requirements
Module: video_byte_packer

---
 rtl/video_pkg.sv | 36 +++
 rtl/video_byte_packer_if.sv | 35 +++
 rtl/video_pixel_formatter.sv | 46 ++++
 rtl/video_byte_packer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared definitions for the video byte packer: FSM encoding, legal
// PORT_NUM/MEM_BYTES codes and helpers used by the top, the interface
// and the pixel formatter.
package video_pkg;

    typedef enum logic [1:0] {
        S_WAIT_VS = 2'd0,
        S_LINE    = 2'd1,
        S_FLUSH   = 2'd2
    } state_t;

    localparam logic [2:0] PORT_NUM_1  = 3'd1;
    localparam logic [2:0] PORT_NUM_2  = 3'd2;
    localparam logic [2:0] PORT_NUM_4  = 3'd4;
    localparam logic [2:0] MEM_BYTES_3 = 3'd3;
    localparam logic [2:0] MEM_BYTES_4 = 3'd4;

    // Smallest accumulator that still covers fill 0..47.
    localparam int MIN_ACC_BYTES = 48;

    // Width of the byte-count field for an out_bytes-wide word.
    function automatic int byte_num_width(input int out_bytes);
        return $clog2(out_bytes) + 1;
    endfunction

    // Anything but 1, 2 or 4 ports is treated as 4 ports.
    function automatic logic [2:0] legal_port_num(input logic [2:0] v);
        return (v == PORT_NUM_1 || v == PORT_NUM_2 || v == PORT_NUM_4) ? v : PORT_NUM_4;
    endfunction

    // Anything but 3 or 4 bytes per pixel is treated as 3 bytes.
    function automatic logic [2:0] legal_mem_bytes(input logic [2:0] v);
        return (v == MEM_BYTES_4) ? MEM_BYTES_4 : MEM_BYTES_3;
    endfunction

endpackage

// File: rtl/video_byte_packer_if.sv
// FIFO write bus of the video byte packer.
// Handshake: a word transfers in every cycle with FIFO_WR_EN_O=1.
// FIFO_FULL_I is not backpressure: a word presented while FIFO_FULL_I=1
// is dropped (FIFO_WR_EN_O stays 0) and the producer moves on. SOF_O and
// FIFO_WR_BYTE_NUM_O are only meaningful together with FIFO_WR_EN_O.
interface video_byte_packer_if
    import video_pkg::*;
#(
    parameter int C_OUT_BYTES = 32
);
    localparam int BN_W = byte_num_width(C_OUT_BYTES);

    logic                     FIFO_FULL_I;
    logic                     FIFO_WR_EN_O;
    logic [C_OUT_BYTES*8-1:0] FIFO_WR_DATA_O;
    logic [BN_W-1:0]          FIFO_WR_BYTE_NUM_O;
    logic                     SOF_O;

    modport master (
        input  FIFO_FULL_I,
        output FIFO_WR_EN_O,
        output FIFO_WR_DATA_O,
        output FIFO_WR_BYTE_NUM_O,
        output SOF_O
    );

    modport slave (
        output FIFO_FULL_I,
        input  FIFO_WR_EN_O,
        input  FIFO_WR_DATA_O,
        input  FIFO_WR_BYTE_NUM_O,
        input  SOF_O
    );

endinterface

// File: rtl/video_pixel_formatter.sv
// Turns one beat of up to C_MAX_PORT_NUM pixels into a contiguous byte
// string: per pixel {B,G,R} low to high, plus a 0x00 pad after R in
// 4-byte mode; port 0 lands in the lowest bytes. Components wider than
// 8 bits contribute their 8 MSBs.
module video_pixel_formatter
    import video_pkg::*;
#(
    parameter int C_MAX_PORT_NUM = 4,
    parameter int C_MAX_BPC      = 8,
    parameter int CNT_W          = $clog2(C_MAX_PORT_NUM*4 + 1)
) (
    input  logic [C_MAX_PORT_NUM*C_MAX_BPC-1:0] r,
    input  logic [C_MAX_PORT_NUM*C_MAX_BPC-1:0] g,
    input  logic [C_MAX_PORT_NUM*C_MAX_BPC-1:0] b,
    input  logic [2:0]                          port_num,
    input  logic [2:0]                          mem_bytes,
    output logic [C_MAX_PORT_NUM*32-1:0]        pix_bytes,
    output logic [CNT_W-1:0]                    pix_cnt
);

    function automatic logic [7:0] msb8(input logic [C_MAX_BPC-1:0] c);
        logic [C_MAX_BPC+7:0] ext;
        ext = {c, 8'h00};
        return ext[C_MAX_BPC+7 -: 8];
    endfunction

    // Place each active port's bytes at p*3 or p*4; inactive ports stay zero.
    always_comb begin
        pix_bytes = '0;
        for (int p = 0; p < C_MAX_PORT_NUM; p++) begin
            if (p < int'(port_num)) begin
                if (mem_bytes == MEM_BYTES_4) begin
                    pix_bytes[p*32 +: 24] = {msb8(r[p*C_MAX_BPC +: C_MAX_BPC]),
                                             msb8(g[p*C_MAX_BPC +: C_MAX_BPC]),
                                             msb8(b[p*C_MAX_BPC +: C_MAX_BPC])};
                end else begin
                    pix_bytes[p*24 +: 24] = {msb8(r[p*C_MAX_BPC +: C_MAX_BPC]),
                                             msb8(g[p*C_MAX_BPC +: C_MAX_BPC]),
                                             msb8(b[p*C_MAX_BPC +: C_MAX_BPC])};
                end
            end
        end
        pix_cnt = CNT_W'(port_num) * CNT_W'(mem_bytes);
    end

endmodule

// File: rtl/video_byte_packer.sv
// Video byte packer: accumulates formatted pixel bytes and writes
// C_OUT_BYTES-wide words into a FIFO, flushing a partial word at the end
// of every line. Optional macro VIDEO_BYTE_PACKER_DROP_CNT_EN adds a
// saturating 16-bit dropped-word counter on DROP_CNT_O.
module video_byte_packer
    import video_pkg::*;
#(
    parameter int C_MAX_PORT_NUM = 4,
    parameter int C_MAX_BPC      = 8,
    parameter int C_OUT_BYTES    = 32
) (
    input  logic                                VID_CLK_I,
    input  logic                                VID_RSTN_I,
    input  logic                                VS_I,
    input  logic                                HS_I,
    input  logic                                DE_I,
    input  logic [C_MAX_PORT_NUM*C_MAX_BPC-1:0] R_I,
    input  logic [C_MAX_PORT_NUM*C_MAX_BPC-1:0] G_I,
    input  logic [C_MAX_PORT_NUM*C_MAX_BPC-1:0] B_I,
    input  logic [2:0]                          PORT_NUM_I,
    input  logic [2:0]                          MEM_BYTES_I,
    video_byte_packer_if.master                 fifo_if,
    output logic                                OVERFLOW_O,
`ifdef VIDEO_BYTE_PACKER_DROP_CNT_EN
    output logic [15:0]                         DROP_CNT_O,
`endif
    output state_t                              DBG_STATE_O
);

    localparam int PIX_BYTES = C_MAX_PORT_NUM * 4;
    localparam int ACC_BYTES = (C_OUT_BYTES + PIX_BYTES > MIN_ACC_BYTES) ?
                               (C_OUT_BYTES + PIX_BYTES) : MIN_ACC_BYTES;
    localparam int ACC_W     = ACC_BYTES * 8;
    localparam int OUT_W     = C_OUT_BYTES * 8;
    localparam int FILL_W    = $clog2(ACC_BYTES + 1);
    localparam int SUM_W     = FILL_W + 1;
    localparam int CNT_W     = $clog2(PIX_BYTES + 1);
    localparam int BN_W      = byte_num_width(C_OUT_BYTES);

    state_t             state;
    logic               vs_d;
    logic [2:0]         cfg_port;
    logic [2:0]         cfg_mem;
    logic [ACC_W-1:0]   acc;
    logic [FILL_W-1:0]  fill;
    logic               wr_valid;
    logic [OUT_W-1:0]   wr_data;
    logic [BN_W-1:0]    wr_bn;
    logic               sof_q;
    logic               sof_pend;
    logic               overflow;

    logic [PIX_BYTES*8-1:0] pix_bytes;
    logic [CNT_W-1:0]       pix_cnt;
    logic [SUM_W-1:0]       sum;
    logic [ACC_W-1:0]       merged;
    logic                   vs_rise;
    logic                   drop;
    logic                   unused_hs;

    assign unused_hs = HS_I;

    video_pixel_formatter #(
        .C_MAX_PORT_NUM (C_MAX_PORT_NUM),
        .C_MAX_BPC      (C_MAX_BPC),
        .CNT_W          (CNT_W)
    ) u_formatter (
        .r         (R_I),
        .g         (G_I),
        .b         (B_I),
        .port_num  (cfg_port),
        .mem_bytes (cfg_mem),
        .pix_bytes (pix_bytes),
        .pix_cnt   (pix_cnt)
    );

    // Append the incoming bytes right above the current fill level.
    always_comb begin
        vs_rise = VS_I & ~vs_d;
        sum     = SUM_W'(fill) + SUM_W'(pix_cnt);
        merged  = acc | (ACC_W'(pix_bytes) << {fill, 3'b000});
        drop    = wr_valid & fifo_if.FIFO_FULL_I;
    end

    // Frame/line FSM with the byte accumulator and registered word outputs.
    // Beats arriving in S_FLUSH are accepted like S_LINE beats (fill is 0
    // there), so a one-cycle horizontal blank loses no pixels.
    always_ff @(posedge VID_CLK_I or negedge VID_RSTN_I) begin
        if (!VID_RSTN_I) begin
            state    <= S_WAIT_VS;
            vs_d     <= 1'b0;
            cfg_port <= PORT_NUM_4;
            cfg_mem  <= MEM_BYTES_3;
            acc      <= '0;
            fill     <= '0;
            wr_valid <= 1'b0;
            wr_data  <= '0;
            wr_bn    <= '0;
            sof_q    <= 1'b0;
            sof_pend <= 1'b0;
            overflow <= 1'b0;
        end else begin
            vs_d     <= VS_I;
            wr_valid <= 1'b0;
            wr_data  <= '0;
            wr_bn    <= '0;
            sof_q    <= 1'b0;
            if (drop) begin
                overflow <= 1'b1;
            end
            if (vs_rise) begin
                state    <= S_LINE;
                acc      <= '0;
                fill     <= '0;
                cfg_port <= legal_port_num(PORT_NUM_I);
                cfg_mem  <= legal_mem_bytes(MEM_BYTES_I);
                sof_pend <= 1'b1;
            end else begin
                case (state)
                    S_WAIT_VS: begin
                        state <= S_WAIT_VS;
                    end
                    S_LINE, S_FLUSH: begin
                        state <= S_LINE;
                        if (DE_I) begin
                            if (sum >= SUM_W'(C_OUT_BYTES)) begin
                                wr_valid <= 1'b1;
                                wr_data  <= merged[OUT_W-1:0];
                                wr_bn    <= BN_W'(C_OUT_BYTES);
                                sof_q    <= sof_pend;
                                sof_pend <= 1'b0;
                                acc      <= merged >> OUT_W;
                                fill     <= FILL_W'(sum - SUM_W'(C_OUT_BYTES));
                            end else begin
                                acc  <= merged;
                                fill <= FILL_W'(sum);
                            end
                        end else if (fill != '0) begin
                            // Bytes above fill are always zero, so the low
                            // word is already the zero-padded partial word.
                            state    <= S_FLUSH;
                            wr_valid <= 1'b1;
                            wr_data  <= acc[OUT_W-1:0];
                            wr_bn    <= BN_W'(fill);
                            sof_q    <= sof_pend;
                            sof_pend <= 1'b0;
                            acc      <= '0;
                            fill     <= '0;
                        end
                    end
                    default: begin
                        state <= S_WAIT_VS;
                    end
                endcase
            end
        end
    end

`ifdef VIDEO_BYTE_PACKER_DROP_CNT_EN
    logic [15:0] drop_cnt;

    // Saturating count of words dropped on a full FIFO.
    always_ff @(posedge VID_CLK_I or negedge VID_RSTN_I) begin
        if (!VID_RSTN_I) begin
            drop_cnt <= '0;
        end else if (drop && drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

    assign DROP_CNT_O = drop_cnt;
`endif

    assign fifo_if.FIFO_WR_EN_O       = wr_valid & ~fifo_if.FIFO_FULL_I;
    assign fifo_if.FIFO_WR_DATA_O     = wr_data;
    assign fifo_if.FIFO_WR_BYTE_NUM_O = wr_bn;
    assign fifo_if.SOF_O              = sof_q & ~fifo_if.FIFO_FULL_I;
    assign OVERFLOW_O                 = overflow;
    assign DBG_STATE_O                = state;

endmodule
